riscv_su_nest_ctrl: RTL

Nested-interrupt stacking/unstacking controller for the RISC-V core. It succeeds the single-level stacking/unstacking arbiter with:
- a parametrised nesting depth and a per-level priority stack;
- a per-word frame transfer handshake towards the stack memory port;
- priority-based preemption, abort flush and overflow reporting.

It sits between the interrupt controller (requests, priorities, returns) and the core's stack memory interface.

---
 rtl/riscv_su_nest_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/riscv_su_nest_ctrl.sv
// Nested-interrupt stacking/unstacking controller: per-level priority stack and per-word frame handshake.
// Optional tail-chaining on return is enabled by defining RISCV_SU_TAILCHAIN_EN.
module riscv_su_nest_ctrl #(
    parameter int NEST_DEPTH   = 4,
    parameter int FRAME_WORDS  = 16,
    parameter int PRIO_WIDTH   = 3,
    parameter int SU_FSM_WIDTH = 3,
    localparam int WW = $clog2(FRAME_WORDS),
    localparam int LW = $clog2(NEST_DEPTH),
    localparam int DW = $clog2(NEST_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    i_abort,
    input  logic                    i_irq_req,
    input  logic [PRIO_WIDTH-1:0]   i_irq_prio,
    input  logic                    i_ret_interr,
    input  logic                    i_mem_ack,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [WW-1:0]           o_word_idx,
    output logic [LW-1:0]           o_frame_level,
    output logic [DW-1:0]           o_depth,
    output logic [PRIO_WIDTH-1:0]   o_cur_prio,
    output logic                    o_irq_accept,
    output logic                    o_nest_full,
    output logic [SU_FSM_WIDTH-1:0] o_fsm_status
);

    typedef enum logic [SU_FSM_WIDTH-1:0] {
        IDLE       = SU_FSM_WIDTH'(0),
        STACKING   = SU_FSM_WIDTH'(1),
        ACTIVE     = SU_FSM_WIDTH'(2),
        PREEMPT    = SU_FSM_WIDTH'(3),
        UNSTACKING = SU_FSM_WIDTH'(4),
        ABORTING   = SU_FSM_WIDTH'(5)
    } state_t;

    localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(NEST_DEPTH);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    state_t                               state;
    logic [NEST_DEPTH-1:0][PRIO_WIDTH-1:0] prio_stk;
    logic [PRIO_WIDTH-1:0]                prev_prio;
    logic [LW-1:0]                        top_lvl;
    logic                                 req_hi;

    assign o_fsm_status = state;
    assign top_lvl      = LW'(o_depth - DEPTH_ONE);
    assign req_hi       = enable && i_irq_req && (i_irq_prio > o_cur_prio);
    assign o_nest_full  = (state == ACTIVE) && req_hi && (o_depth == DEPTH_MAX);

    // Priority of the frame just below the top one; 0 when the top frame is the only one.
    always_comb begin
        prev_prio = '0;
        for (int i = 0; i < NEST_DEPTH - 1; i++)
            if (DW'(i + 2) == o_depth) prev_prio = prio_stk[i];
    end

`ifdef RISCV_SU_TAILCHAIN_EN
    logic tc_ok;
    assign tc_ok = enable && i_irq_req && ((o_depth == DEPTH_ONE) || (i_irq_prio > prev_prio));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            prio_stk      <= '0;
            o_mem_req     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_word_idx    <= '0;
            o_frame_level <= '0;
            o_depth       <= '0;
            o_cur_prio    <= '0;
            o_irq_accept  <= 1'b0;
        end else begin
            o_irq_accept <= 1'b0;
            if (i_abort && state != IDLE) begin
                state     <= ABORTING;
                o_mem_req <= 1'b0;
                o_mem_we  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable && i_irq_req) begin
                            prio_stk[0]   <= i_irq_prio;
                            o_word_idx    <= '0;
                            o_frame_level <= '0;
                            o_irq_accept  <= 1'b1;
                            o_mem_req     <= 1'b1;
                            o_mem_we      <= 1'b1;
                            state         <= STACKING;
                        end
                    end
                    STACKING: begin
                        if (i_mem_ack) begin
                            if (o_word_idx == WORD_LAST) begin
                                o_word_idx <= '0;
                                o_depth    <= o_depth + DEPTH_ONE;
                                o_cur_prio <= prio_stk[o_frame_level];
                                o_mem_req  <= 1'b0;
                                o_mem_we   <= 1'b0;
                                state      <= ACTIVE;
                            end else begin
                                o_word_idx <= o_word_idx + WW'(1);
                            end
                        end
                    end
                    ACTIVE: begin
                        if (i_ret_interr) begin
`ifdef RISCV_SU_TAILCHAIN_EN
                            if (tc_ok) begin
                                // Reuse the live frame: only its priority changes.
                                prio_stk[top_lvl] <= i_irq_prio;
                                o_cur_prio        <= i_irq_prio;
                                o_irq_accept      <= 1'b1;
                            end else begin
                                o_word_idx    <= '0;
                                o_frame_level <= top_lvl;
                                o_mem_req     <= 1'b1;
                                o_mem_we      <= 1'b0;
                                state         <= UNSTACKING;
                            end
`else
                            o_word_idx    <= '0;
                            o_frame_level <= top_lvl;
                            o_mem_req     <= 1'b1;
                            o_mem_we      <= 1'b0;
                            state         <= UNSTACKING;
`endif
                        end else if (req_hi && o_depth < DEPTH_MAX) begin
                            o_irq_accept <= 1'b1;
                            state        <= PREEMPT;
                        end
                    end
                    PREEMPT: begin
                        prio_stk[LW'(o_depth)] <= i_irq_prio;
                        o_word_idx             <= '0;
                        o_frame_level          <= LW'(o_depth);
                        o_mem_req              <= 1'b1;
                        o_mem_we               <= 1'b1;
                        state                  <= STACKING;
                    end
                    UNSTACKING: begin
                        if (i_mem_ack) begin
                            if (o_word_idx == WORD_LAST) begin
                                o_word_idx              <= '0;
                                prio_stk[o_frame_level] <= '0;
                                o_depth                 <= o_depth - DEPTH_ONE;
                                o_cur_prio              <= prev_prio;
                                o_mem_req               <= 1'b0;
                                state                   <= (o_depth == DEPTH_ONE) ? IDLE : ACTIVE;
                            end else begin
                                o_word_idx <= o_word_idx + WW'(1);
                            end
                        end
                    end
                    default: begin
                        // ABORTING and unused codes: park until abort drops, then flush everything.
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                        if (!i_abort) begin
                            prio_stk      <= '0;
                            o_word_idx    <= '0;
                            o_frame_level <= '0;
                            o_depth       <= '0;
                            o_cur_prio    <= '0;
                            state         <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule
